// File: rtl/saturn_decoder_defs.sv
// Shared definitions for the Saturn control-flow front-end decoder:
// FSM state encoding, jump length codes and opcode nibble values.
package saturn_decoder_defs;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BLK0 = 3'd1,
        BLK8 = 3'd2,
        OFFS = 3'd3,
        SKIP = 3'd4
    } state_t;

    // Offset length codes seen by the PC/RSTK unit; offset nibbles = code + 1
    localparam logic [2:0] JL_NONE = 3'd0;
    localparam logic [2:0] JL_REL2 = 3'd1;
    localparam logic [2:0] JL_REL3 = 3'd2;
    localparam logic [2:0] JL_REL4 = 3'd3;
    localparam logic [2:0] JL_ABS5 = 3'd4;

    // First opcode nibble
    localparam logic [3:0] NIB_BLK0   = 4'h0;
    localparam logic [3:0] NIB_GOC    = 4'h4;
    localparam logic [3:0] NIB_GONC   = 4'h5;
    localparam logic [3:0] NIB_GOTO   = 4'h6;
    localparam logic [3:0] NIB_GOSUB  = 4'h7;
    localparam logic [3:0] NIB_BLK8   = 4'h8;

    // Second opcode nibble after 8
    localparam logic [3:0] NIB_GOLONG = 4'hC;
    localparam logic [3:0] NIB_GOVLNG = 4'hD;
    localparam logic [3:0] NIB_GOSUBL = 4'hE;
    localparam logic [3:0] NIB_GOSBVL = 4'hF;

    // Highest RTN selector after a leading 0 (RTNSXM/RTN/RTNSC/RTNCC)
    localparam logic [3:0] NIB_RTN_MAX = 4'h3;

    // Untaken GOC/GONC still swallows its 2-nibble offset; last index is 1
    localparam logic [2:0] SKIP_LAST = 3'd1;

endpackage

// File: rtl/saturn_jump_decoder.sv
// Nibble-serial decoder for Saturn control-flow opcodes. Recognises
// GOTO/GOSUB/GOC/GONC/GOLONG/GOVLNG/GOSUBL/GOSBVL and RTN 00..03, and drives
// the PC/RSTK unit's jump controls for the whole length of the instruction.
module saturn_jump_decoder
    import saturn_decoder_defs::*;
#(
    parameter bit SUPPORT_GOC = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clk_en,
    input  logic [3:0] i_phases,
    input  logic       i_bus_busy,
    input  logic       i_exec_unit_busy,
    input  logic [3:0] i_nibble,
    input  logic       i_carry,
    output logic       o_jump_instr,
    output logic [2:0] o_jump_length,
    output logic       o_push_pc,
    output logic       o_block_0x,
    output logic       o_rtn_instr,
    output logic       o_instr_done,
    output logic       o_unhandled,
    output logic       o_busy
);

    state_t     state;
    logic [2:0] cnt;
    logic       adv;
    logic       goc_taken;

    // A nibble is consumed only on phase 2 of an unstalled, enabled cycle
    assign adv       = i_clk_en && !i_bus_busy && !i_exec_unit_busy && i_phases[2];
    // GOC branches on carry set, GONC on carry clear
    assign goc_taken = (i_nibble == NIB_GOC) ? i_carry : !i_carry;
    assign o_busy    = (state != IDLE);

    // Decode FSM; pulse outputs clear every clock, level outputs move only on adv
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            cnt           <= 3'd0;
            o_jump_instr  <= 1'b0;
            o_jump_length <= JL_NONE;
            o_push_pc     <= 1'b0;
            o_block_0x    <= 1'b0;
            o_rtn_instr   <= 1'b0;
            o_instr_done  <= 1'b0;
            o_unhandled   <= 1'b0;
        end else begin
            o_rtn_instr  <= 1'b0;
            o_instr_done <= 1'b0;
            o_unhandled  <= 1'b0;
            if (adv) begin
                case (state)
                    IDLE: begin
                        case (i_nibble)
                            NIB_BLK0: begin
                                o_block_0x <= 1'b1;
                                state      <= BLK0;
                            end
                            NIB_BLK8: state <= BLK8;
                            NIB_GOTO, NIB_GOSUB: begin
                                o_jump_instr  <= 1'b1;
                                o_jump_length <= JL_REL3;
                                o_push_pc     <= (i_nibble == NIB_GOSUB);
                                cnt           <= 3'd0;
                                state         <= OFFS;
                            end
                            NIB_GOC, NIB_GONC: begin
                                if (!SUPPORT_GOC) begin
                                    o_unhandled <= 1'b1;
                                end else if (goc_taken) begin
                                    o_jump_instr  <= 1'b1;
                                    o_jump_length <= JL_REL2;
                                    o_push_pc     <= 1'b0;
                                    cnt           <= 3'd0;
                                    state         <= OFFS;
                                end else begin
                                    // Not taken: swallow the offset without telling the PC unit
                                    cnt   <= 3'd0;
                                    state <= SKIP;
                                end
                            end
                            default: o_unhandled <= 1'b1;
                        endcase
                    end
                    BLK0: begin
                        o_block_0x <= 1'b0;
                        state      <= IDLE;
                        if (i_nibble <= NIB_RTN_MAX) begin
                            o_rtn_instr  <= 1'b1;
                            o_instr_done <= 1'b1;
                        end else begin
                            o_unhandled <= 1'b1;
                        end
                    end
                    BLK8: begin
                        case (i_nibble)
                            NIB_GOLONG, NIB_GOVLNG, NIB_GOSUBL, NIB_GOSBVL: begin
                                // Bit 0 picks absolute vs relative, bit 1 picks the GOSUB form
                                o_jump_instr  <= 1'b1;
                                o_jump_length <= i_nibble[0] ? JL_ABS5 : JL_REL4;
                                o_push_pc     <= i_nibble[1];
                                cnt           <= 3'd0;
                                state         <= OFFS;
                            end
                            default: begin
                                o_unhandled <= 1'b1;
                                state       <= IDLE;
                            end
                        endcase
                    end
                    OFFS: begin
                        // Drop jump_instr on the edge the PC unit takes the last offset nibble
                        if (cnt == o_jump_length) begin
                            o_jump_instr  <= 1'b0;
                            o_jump_length <= JL_NONE;
                            o_push_pc     <= 1'b0;
                            o_instr_done  <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    SKIP: begin
                        if (cnt == SKIP_LAST) begin
                            o_instr_done <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_saturn_jump_decoder.sv
// Self-checking bench for saturn_jump_decoder: an instruction-level model
// (nibble counts per opcode) predicts every output each cycle; directed
// sequences add hand-computed literal expectations.
module tb_saturn_jump_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic [3:0] phases;
    logic       bus_busy;
    logic       exec_busy;
    logic [3:0] nibble;
    logic       carry;

    logic       jump_instr;
    logic [2:0] jump_length;
    logic       push_pc;
    logic       block_0x;
    logic       rtn_instr;
    logic       instr_done;
    logic       unhandled;
    logic       busy;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // model state
    int         ilen = 0;    // nibbles consumed in current instruction
    int         tot  = 0;    // total nibbles of current jump/skip instruction
    int         op0  = 0;
    logic       exp_jump = 1'b0;
    logic [2:0] exp_len  = 3'd0;
    logic       exp_push = 1'b0;
    logic       exp_blk  = 1'b0;
    logic       exp_rtn  = 1'b0;
    logic       exp_done = 1'b0;
    logic       exp_unh  = 1'b0;

    always #5 clk = ~clk;

    saturn_jump_decoder #(.SUPPORT_GOC(1'b1)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_clk_en         (clk_en),
        .i_phases         (phases),
        .i_bus_busy       (bus_busy),
        .i_exec_unit_busy (exec_busy),
        .i_nibble         (nibble),
        .i_carry          (carry),
        .o_jump_instr     (jump_instr),
        .o_jump_length    (jump_length),
        .o_push_pc        (push_pc),
        .o_block_0x       (block_0x),
        .o_rtn_instr      (rtn_instr),
        .o_instr_done     (instr_done),
        .o_unhandled      (unhandled),
        .o_busy           (busy)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic start_jump(input int len, input bit push, input int oplen);
        exp_jump = 1'b1;
        exp_len  = 3'(len);
        exp_push = push;
        tot      = oplen + len + 1;
    endtask

    // Instruction-level reference: what has been consumed so far decides the outputs
    task automatic model_step();
        int n;
        bit adv;
        n   = int'(nibble);
        adv = clk_en && !bus_busy && !exec_busy && phases[2];
        exp_rtn  = 1'b0;
        exp_done = 1'b0;
        exp_unh  = 1'b0;
        if (rst) begin
            ilen = 0; exp_jump = 0; exp_len = 0; exp_push = 0; exp_blk = 0;
        end else if (adv) begin
            ilen++;
            if (ilen == 1) begin
                op0 = n;
                if (n == 0) exp_blk = 1'b1;
                else if (n == 8) begin end
                else if (n == 6 || n == 7) start_jump(2, n == 7, 1);
                else if (n == 4 || n == 5) begin
                    if ((n == 4) ? carry : !carry) start_jump(1, 0, 1);
                    else tot = 3;
                end else begin
                    exp_unh = 1'b1; ilen = 0;
                end
            end else if (op0 == 0) begin
                exp_blk = 1'b0;
                if (n <= 3) begin exp_rtn = 1'b1; exp_done = 1'b1; end
                else exp_unh = 1'b1;
                ilen = 0;
            end else if (op0 == 8 && ilen == 2) begin
                if (n >= 12) start_jump((n % 2 == 1) ? 4 : 3, n >= 14, 2);
                else begin exp_unh = 1'b1; ilen = 0; end
            end else if (ilen == tot) begin
                exp_jump = 0; exp_len = 0; exp_push = 0; exp_done = 1'b1; ilen = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic feed(input logic [3:0] n);
        phases    = 4'b0100;
        clk_en    = 1'b1;
        bus_busy  = 1'b0;
        exec_busy = 1'b0;
        nibble    = n;
        tick();
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("jump_instr", {3'b0, jump_instr}, {3'b0, exp_jump});
            chk("jump_length", {1'b0, jump_length}, {1'b0, exp_len});
            chk("push_pc", {3'b0, push_pc}, {3'b0, exp_push});
            chk("block_0x", {3'b0, block_0x}, {3'b0, exp_blk});
            chk("rtn_instr", {3'b0, rtn_instr}, {3'b0, exp_rtn});
            chk("instr_done", {3'b0, instr_done}, {3'b0, exp_done});
            chk("unhandled", {3'b0, unhandled}, {3'b0, exp_unh});
            chk("busy", {3'b0, busy}, {3'b0, 1'(ilen != 0)});
        end
    end

    initial begin
        rst = 1'b1; clk_en = 1'b0; phases = 4'b0001; bus_busy = 1'b0;
        exec_busy = 1'b0; nibble = 4'h0; carry = 1'b0;
        tick();
        tick();
        cmp_en = 1'b1;
        chk("reset_busy", {3'b0, busy}, 4'd0);
        chk("reset_jump", {3'b0, jump_instr}, 4'd0);
        chk("reset_len", {1'b0, jump_length}, 4'd0);
        rst = 1'b0;

        // GOTO 6,3,2,1
        feed(4'h6);
        chk("goto_jump", {3'b0, jump_instr}, 4'd1);
        chk("goto_len", {1'b0, jump_length}, 4'd2);
        chk("goto_push", {3'b0, push_pc}, 4'd0);
        feed(4'h3);
        feed(4'h2);
        chk("goto_jump_mid", {3'b0, jump_instr}, 4'd1);
        feed(4'h1);
        chk("goto_done", {3'b0, instr_done}, 4'd1);
        chk("goto_fall", {3'b0, jump_instr}, 4'd0);

        // GOSBVL 8,F,0,0,1,2,3
        feed(4'h8);
        feed(4'hF);
        chk("gosbvl_len", {1'b0, jump_length}, 4'd4);
        chk("gosbvl_push", {3'b0, push_pc}, 4'd1);
        feed(4'h0); feed(4'h0); feed(4'h1); feed(4'h2);
        chk("gosbvl_nodone", {3'b0, instr_done}, 4'd0);
        feed(4'h3);
        chk("gosbvl_done", {3'b0, instr_done}, 4'd1);

        // RTN 0,1 then 0,5
        feed(4'h0);
        chk("rtn_blk", {3'b0, block_0x}, 4'd1);
        feed(4'h1);
        chk("rtn_pulse", {3'b0, rtn_instr}, 4'd1);
        chk("rtn_done", {3'b0, instr_done}, 4'd1);
        chk("rtn_blkclr", {3'b0, block_0x}, 4'd0);
        feed(4'h0);
        feed(4'h5);
        chk("blk0_unh", {3'b0, unhandled}, 4'd1);
        chk("blk0_nortn", {3'b0, rtn_instr}, 4'd0);

        // GOC not taken, then taken
        carry = 1'b0;
        feed(4'h4);
        chk("goc_nt_jump", {3'b0, jump_instr}, 4'd0);
        chk("goc_nt_busy", {3'b0, busy}, 4'd1);
        feed(4'hA);
        feed(4'hB);
        chk("goc_nt_done", {3'b0, instr_done}, 4'd1);
        carry = 1'b1;
        feed(4'h4);
        chk("goc_t_len", {1'b0, jump_length}, 4'd1);
        chk("goc_t_jump", {3'b0, jump_instr}, 4'd1);
        feed(4'h9);
        feed(4'h9);
        chk("goc_t_done", {3'b0, instr_done}, 4'd1);

        // GOSUB with a 3-cycle bus stall between offset nibbles
        feed(4'h7);
        feed(4'h1);
        bus_busy = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_jump", {3'b0, jump_instr}, 4'd1);
            chk("stall_nodone", {3'b0, instr_done}, 4'd0);
        end
        feed(4'h2);
        chk("stall_still", {3'b0, jump_instr}, 4'd1);
        feed(4'h3);
        chk("stall_done", {3'b0, instr_done}, 4'd1);

        // Reset mid GOLONG, then a clean GOTO
        feed(4'h8); feed(4'hC); feed(4'h5);
        rst = 1'b1;
        tick();
        chk("rst_jump", {3'b0, jump_instr}, 4'd0);
        chk("rst_busy", {3'b0, busy}, 4'd0);
        chk("rst_nodone", {3'b0, instr_done}, 4'd0);
        rst = 1'b0;
        feed(4'h6); feed(4'h0); feed(4'h0); feed(4'h0);
        chk("post_rst_done", {3'b0, instr_done}, 4'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            phases    = ($urandom_range(0, 1) == 0) ? 4'b0100 : 4'(1 << $urandom_range(0, 3));
            clk_en    = ($urandom_range(0, 9) != 0);
            bus_busy  = ($urandom_range(0, 7) == 0);
            exec_busy = ($urandom_range(0, 7) == 0);
            carry     = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 6))
                    0: nibble = 4'h0;
                    1: nibble = 4'h8;
                    2: nibble = 4'h6;
                    3: nibble = 4'h7;
                    4: nibble = 4'h4;
                    5: nibble = 4'h5;
                    default: nibble = 4'(12 + $urandom_range(0, 3));
                endcase
            end else begin
                nibble = 4'($urandom_range(0, 15));
            end
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
